// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding and width helpers for the cache controller
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_ALLOC = 3'd2,
        ST_COMP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) r++;
        return r;
    endfunction

    function automatic int sel_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    // Offset covers the word index plus the byte bit within a 16-bit word.
    function automatic int off_w(input int words);
        return clog2(words) + 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int index_w, input int words);
        return addr_w - index_w - off_w(words);
    endfunction

    function automatic logic [7:0] onehot8(input int unsigned idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/miss_return_tracker.sv
// rtl/miss_return_tracker.sv - memory return tracker and line word counter
module miss_return_tracker #(
    parameter int MEM_LAT = 2,
    parameter int WCNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic              wb_adv,
    output logic              fill_we,
    output logic [WCNT_W-1:0] fill_word,
    output logic              fill_last
);

    logic [MEM_LAT-1:0] pipe;

    // The word counter is shared: writeback steps it on accepted writes, fill on returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe      <= '0;
            fill_word <= '0;
        end else if (clear) begin
            pipe      <= '0;
            fill_word <= '0;
        end else begin
            pipe <= (pipe << 1) | MEM_LAT'(issue);
            if (fill_we || wb_adv)
                fill_word <= fill_word + WCNT_W'(1);
        end
    end

    assign fill_we   = pipe[MEM_LAT-1];
    assign fill_last = fill_we && (fill_word == '1);

endmodule

// File: rtl/assoc_cache_ctrl.sv
// rtl/assoc_cache_ctrl.sv - N-way write-back write-allocate cache controller FSM
module assoc_cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      Rd,
    input  logic                                      Wr,
    input  logic [ADDR_W-1:0]                         Addr,
    output logic                                      Done,
    output logic                                      Stall,
    output logic                                      CacheHit,
    output logic                                      err,
    input  logic [WAYS-1:0]                           way_hit,
    input  logic [WAYS-1:0]                           way_valid,
    input  logic [WAYS-1:0]                           way_dirty,
    input  logic [WAYS*tag_w(ADDR_W,INDEX_W,WORDS)-1:0] way_tag,
    output logic                                      c_enable,
    output logic                                      c_comp,
    output logic [WAYS-1:0]                           c_write,
    output logic                                      c_valid_in,
    output logic [off_w(WORDS)-1:0]                   c_offset,
    output logic                                      c_fill,
    output logic [sel_w(WAYS)-1:0]                    sel_way,
    output logic [ADDR_W-1:0]                         mem_addr,
    output logic                                      mem_rd,
    output logic                                      mem_wr,
    input  logic                                      mem_stall
);

    localparam int SEL_W  = sel_w(WAYS);
    localparam int OFF_W  = off_w(WORDS);
    localparam int TAG_W  = tag_w(ADDR_W, INDEX_W, WORDS);
    localparam int WCNT_W = clog2(WORDS);
    localparam int ICNT_W = WCNT_W + 1;

    state_t             state;
    logic [SEL_W-1:0]   vway, vptr, hit_idx, inv_idx, miss_way;
    logic [TAG_W-1:0]   vtag, vic_tag;
    logic [ICNT_W-1:0]  icnt;
    logic [WAYS-1:0]    hits;
    logic [WCNT_W-1:0]  wcnt;
    logic               from_ptr, any_inv, vic_dirty, multi_hit, req;
    logic               issuing, issue, wb_adv, fill_we, fill_last;

    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_index;

    assign cpu_tag   = Addr[ADDR_W-1 -: TAG_W];
    assign cpu_index = Addr[OFF_W +: INDEX_W];
    assign req       = Rd ^ Wr;
    assign hits      = way_hit & way_valid;
    assign multi_hit = |(hits & (hits - WAYS'(1)));
    assign issuing   = (state == ST_ALLOC) && (icnt < ICNT_W'(WORDS));
    assign issue     = issuing && !mem_stall;
    assign wb_adv    = (state == ST_WB) && !mem_stall;

    // Lowest-index hit wins; an invalid way is preferred over the round-robin pointer.
    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        any_inv = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hits[i]) hit_idx = SEL_W'(i);
            if (!way_valid[i]) begin
                inv_idx = SEL_W'(i);
                any_inv = 1'b1;
            end
        end
        miss_way = any_inv ? inv_idx : vptr;
    end

    always_comb begin
        vic_tag   = '0;
        vic_dirty = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (SEL_W'(i) == miss_way) begin
                vic_tag   = way_tag[i*TAG_W +: TAG_W];
                vic_dirty = way_valid[i] & way_dirty[i];
            end
        end
    end

    miss_return_tracker #(
        .MEM_LAT (MEM_LAT),
        .WCNT_W  (WCNT_W)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_IDLE),
        .issue     (issue),
        .wb_adv    (wb_adv),
        .fill_we   (fill_we),
        .fill_word (wcnt),
        .fill_last (fill_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            icnt     <= '0;
            vptr     <= '0;
            vway     <= '0;
            vtag     <= '0;
            from_ptr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    icnt <= '0;
                    if (req && hits == '0) begin
                        vway     <= miss_way;
                        vtag     <= vic_tag;
                        from_ptr <= !any_inv;
                        state    <= vic_dirty ? ST_WB : ST_ALLOC;
                    end
                end
                ST_WB: begin
                    if (wb_adv && wcnt == '1) state <= ST_ALLOC;
                end
                ST_ALLOC: begin
                    if (issue) icnt <= icnt + ICNT_W'(1);
                    if (fill_last) begin
                        icnt  <= '0;
                        state <= ST_COMP;
                    end
                end
                ST_COMP: state <= ST_DONE;
                ST_DONE: begin
                    if (from_ptr)
                        vptr <= (vptr == SEL_W'(WAYS - 1)) ? '0 : vptr + SEL_W'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Done       = 1'b0;
        Stall      = (state != ST_IDLE);
        CacheHit   = 1'b0;
        err        = 1'b0;
        c_enable   = 1'b0;
        c_comp     = 1'b0;
        c_write    = '0;
        c_valid_in = 1'b0;
        c_offset   = Addr[OFF_W-1:0];
        c_fill     = 1'b0;
        sel_way    = vway;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Rd && Wr) begin
                    err = 1'b1;
                end else if (req) begin
                    c_enable = 1'b1;
                    c_comp   = 1'b1;
                    err      = multi_hit;
                    if (hits != '0) begin
                        sel_way  = hit_idx;
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        if (Wr) c_write = WAYS'(onehot8(32'(hit_idx)));
                    end
                end
            end
            ST_WB: begin
                c_enable = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {vtag, cpu_index, wcnt, 1'b0};
                c_offset = {wcnt, 1'b0};
            end
            ST_ALLOC: begin
                mem_rd   = issuing;
                mem_addr = {cpu_tag, cpu_index, icnt[WCNT_W-1:0], 1'b0};
                if (fill_we) begin
                    c_enable   = 1'b1;
                    c_fill     = 1'b1;
                    c_write    = WAYS'(onehot8(32'(vway)));
                    c_offset   = {wcnt, 1'b0};
                    c_valid_in = fill_last;
                end
            end
            ST_COMP: begin
                c_enable = 1'b1;
                c_comp   = 1'b1;
                if (Wr) c_write = WAYS'(onehot8(32'(vway)));
            end
            ST_DONE: Done = 1'b1;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb/tb_assoc_cache_ctrl.sv - directed bench for assoc_cache_ctrl (2 ways, 4 words, latency 2)
module tb_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst, Rd, Wr, mem_stall;
    logic [15:0] Addr;
    logic        Done, Stall, CacheHit, err;
    logic [1:0]  way_hit, way_valid, way_dirty;
    logic [9:0]  way_tag;
    logic        c_enable, c_comp, c_valid_in, c_fill;
    logic [1:0]  c_write;
    logic [2:0]  c_offset;
    logic [0:0]  sel_way;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(
        .WAYS(2), .WORDS(4), .MEM_LAT(2), .ADDR_W(16), .INDEX_W(8)
    ) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr),
        .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty), .way_tag(way_tag),
        .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_offset(c_offset), .c_fill(c_fill), .sel_way(sel_way),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_stall(mem_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_vic [3];
        exp_vic = '{2'b01, 2'b10, 2'b01};

        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; mem_stall = 1'b0;
        way_hit = '0; way_valid = '0; way_dirty = '0; way_tag = '0;
        #2;
        chk("rst_done", Done, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_hit", CacheHit, 0);
        chk("rst_err", err, 0);
        chk("rst_cwrite", c_write, 0);
        chk("rst_memrd", mem_rd, 0);
        chk("rst_memwr", mem_wr, 0);
        chk("rst_comp", c_comp, 0);
        tick();
        rst = 1'b0;

        // Read miss to an empty set: tag 0x03, index 0x10, word 2
        tick();
        Rd = 1'b1; Addr = 16'h1884;
        #1;
        chk("t1_c0_stall", Stall, 0);
        chk("t1_c0_comp", c_comp, 1);
        chk("t1_c0_offset", c_offset, 3'd4);
        chk("t1_c0_done", Done, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(); #1;
            chk("t1_stall", Stall, 1);
            chk("t1_memrd", mem_rd, (k <= 4));
            if (k <= 4) chk("t1_memaddr", mem_addr, 32'h1880 + 2 * (k - 1));
            chk("t1_cwrite", c_write, (k >= 3 && k <= 6) ? 2'b01 : 2'b00);
            chk("t1_validin", c_valid_in, (k == 6));
            chk("t1_comp", c_comp, (k == 7));
            chk("t1_done", Done, (k == 8));
            chk("t1_hit", CacheHit, 0);
        end

        // Hits, multi-hit and illegal request, all from IDLE
        tick();
        way_valid = 2'b01; way_hit = 2'b01; way_tag = {5'h00, 5'h03};
        #1;
        chk("t2_stall", Stall, 0);
        chk("t2_done", Done, 1);
        chk("t2_hit", CacheHit, 1);
        chk("t2_memrd", mem_rd, 0);
        chk("t2_sel", sel_way, 0);
        chk("t2_cwrite", c_write, 0);
        Rd = 1'b0; Wr = 1'b1; way_valid = 2'b11; way_hit = 2'b10;
        #1;
        chk("t2w_cwrite", c_write, 2'b10);
        chk("t2w_sel", sel_way, 1);
        chk("t2w_done", Done, 1);
        chk("t2w_err", err, 0);
        Rd = 1'b1; Wr = 1'b0; way_hit = 2'b11;
        #1;
        chk("t2m_err", err, 1);
        chk("t2m_sel", sel_way, 0);
        chk("t2m_done", Done, 1);
        Rd = 1'b1; Wr = 1'b1; way_hit = 2'b00;
        #1;
        chk("t2x_err", err, 1);
        chk("t2x_cwrite", c_write, 0);
        chk("t2x_done", Done, 0);
        tick(); #1;
        chk("t2x_stall_next", Stall, 0);
        chk("t2x_memrd_next", mem_rd, 0);
        Rd = 1'b0; Wr = 1'b0;

        // Write miss, dirty victim way 0 with tag 0x05; new tag 0x09, index 0x22
        tick();
        way_valid = 2'b11; way_dirty = 2'b01; way_hit = 2'b00; way_tag = {5'h07, 5'h05};
        Wr = 1'b1; Addr = 16'h4910;
        #1;
        chk("t3_c0_stall", Stall, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(); #1;
            chk("t3_stall", Stall, 1);
            chk("t3_memwr", mem_wr, (k <= 4));
            if (k <= 4) begin
                chk("t3_wbaddr", mem_addr, 32'h2910 + 2 * (k - 1));
                chk("t3_wboff", c_offset, 2 * (k - 1));
                chk("t3_wbsel", sel_way, 0);
            end
            chk("t3_memrd", mem_rd, (k >= 5 && k <= 8));
            if (k >= 5 && k <= 8) chk("t3_rdaddr", mem_addr, 32'h4910 + 2 * (k - 5));
            chk("t3_cwrite", c_write, (k >= 7 && k <= 11) ? 2'b01 : 2'b00);
            chk("t3_fill", c_fill, (k >= 7 && k <= 10));
            chk("t3_validin", c_valid_in, (k == 10));
            chk("t3_done", Done, (k == 12));
        end

        // Read miss to empty set with the word-1 issue stalled once
        tick();
        Wr = 1'b0; Rd = 1'b1; Addr = 16'h0980;
        way_valid = 2'b00; way_dirty = 2'b00; way_hit = 2'b00;
        #1;
        chk("t4_c0_stall", Stall, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            mem_stall = (k == 2);
            #1;
            chk("t4_memrd", mem_rd, (k <= 5));
            if (k <= 5)
                chk("t4_memaddr", mem_addr,
                    32'h0980 + 2 * ((k == 1) ? 0 : (k <= 3) ? 1 : k - 2));
            chk("t4_cwrite", c_write, (k == 3 || k == 5 || k == 6 || k == 7) ? 2'b01 : 2'b00);
            chk("t4_validin", c_valid_in, (k == 7));
            chk("t4_done", Done, (k == 9));
        end

        // Dirty miss takes pointer victim way 1; reset during writeback
        tick();
        mem_stall = 1'b0; Rd = 1'b0; Wr = 1'b1; Addr = 16'h4910;
        way_valid = 2'b11; way_dirty = 2'b11; way_hit = 2'b00;
        #1;
        chk("t6_c0_stall", Stall, 0);
        tick(); #1;
        chk("t6_wb_memwr", mem_wr, 1);
        chk("t6_wb_stall", Stall, 1);
        chk("t6_wb_sel", sel_way, 1);
        chk("t6_wb_addr", mem_addr, 32'h3910);
        rst = 1'b1; Wr = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_stall", Stall, 0);
        chk("t6_rst_memwr", mem_wr, 0);
        tick(); #1;
        chk("t6_next_stall", Stall, 0);
        chk("t6_next_memwr", mem_wr, 0);
        chk("t6_next_memrd", mem_rd, 0);

        // Round-robin victims over three clean misses to index 0x10
        way_valid = 2'b11; way_dirty = 2'b00; way_hit = 2'b00;
        for (int m = 0; m < 3; m++) begin
            tick();
            Rd = 1'b1;
            Addr = 16'(((32'h11 + m) << 11) | 32'h80);
            #1;
            chk("t5_c0_stall", Stall, 0);
            for (int k = 1; k <= 8; k++) begin
                tick(); #1;
                if (k == 3) chk("t5_victim", c_write, exp_vic[m]);
                if (k == 8) chk("t5_done", Done, 1);
            end
        end
        tick();
        Rd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
